fetch_stage: RTL and testbench

Instruction fetch stage. Owns the PC, issues in-order requests to instruction memory, buffers responses in a small FIFO and presents instructions and their PCs to the decode stage, where immediate selection consumes `instr`. A redirect from execute (taken branch, JAL, JALR) flushes buffered and in-flight instructions and restarts fetch at the new target.

---
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests under a
// credit limit, buffers responses with their PCs and presents them to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned   CW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned   PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]   DEPTH = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] kill;
  logic [CW-1:0] count;

  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic [31:0]   aq [FIFO_DEPTH];
  logic [PW-1:0] aq_rd;
  logic [PW-1:0] aq_wr;

  logic          pop;
  logic          fire;
  logic          discard;
  logic          push;
  logic [CW:0]   credit_used;
  logic          unused_bits;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign unused_bits = &{1'b0, redirect_pc[1:0]};

  assign instr_valid = rst_n & (count != '0);
  assign pop         = instr_valid & id_ready;

  // Credits freed by this cycle's pop are reusable immediately, so id_ready
  // reaches imem_req_valid combinationally.
  assign credit_used    = {1'b0, outstanding} + {1'b0, count} - {{CW{1'b0}}, pop};
  assign imem_req_valid = rst_n & ~redirect_valid & (credit_used < DEPTH);
  assign imem_req_addr  = pc;
  assign fire           = imem_req_valid & imem_req_ready;

  assign discard = (kill != '0) | redirect_valid;
  assign push    = imem_rsp_valid & ~discard;

  assign instr    = instr_valid ? fifo_data[rd_ptr] : 32'h0000_0013;
  assign instr_pc = instr_valid ? fifo_pc[rd_ptr]   : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      kill        <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      aq_rd       <= '0;
      aq_wr       <= '0;
    end else begin
      if (fire) begin
        pc    <= pc + 32'd4;
        aq_wr <= bump(aq_wr);
      end
      if (imem_rsp_valid) aq_rd <= bump(aq_rd);
      outstanding <= outstanding + CW'(fire) - CW'(imem_rsp_valid);

      if (redirect_valid) begin
        // Everything still in flight after this cycle's response is stale.
        pc     <= {redirect_pc[31:2], 2'b00};
        kill   <= outstanding - CW'(imem_rsp_valid);
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (imem_rsp_valid && kill != '0) kill <= kill - 1'b1;
        if (pop)  rd_ptr <= bump(rd_ptr);
        if (push) wr_ptr <= bump(wr_ptr);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire) aq[aq_wr] <= pc;
    if (push) begin
      fifo_data[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]   <= aq[aq_rd];
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a default instance plus a wrapping-PC
// instance, each fed by its own in-order latency-configurable memory model.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
  } mem_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_ready = 1'b1;
  logic        id_ready = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        a_req_valid, a_rsp_valid, a_instr_valid;
  logic [31:0] a_req_addr, a_rsp_data, a_instr, a_instr_pc;
  logic        b_req_valid, b_rsp_valid, b_instr_valid;
  logic [31:0] b_req_addr, b_rsp_data, b_instr, b_instr_pc;

  mem_t        qa[$];
  mem_t        qb[$];
  int unsigned cyc = 0;
  int unsigned lat = 1;
  logic        last_fire = 1'b0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(a_req_valid), .imem_req_addr(a_req_addr), .imem_req_ready(req_ready),
    .imem_rsp_valid(a_rsp_valid), .imem_rsp_data(a_rsp_data),
    .instr_valid(a_instr_valid), .instr(a_instr), .instr_pc(a_instr_pc),
    .id_ready(id_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(b_req_valid), .imem_req_addr(b_req_addr), .imem_req_ready(req_ready),
    .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
    .instr_valid(b_instr_valid), .instr(b_instr), .instr_pc(b_instr_pc),
    .id_ready(id_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // One clock cycle: present due responses, let the request path settle,
  // book-keep accepted requests, then advance to just after the rising edge.
  task automatic tick();
    a_rsp_valid = 1'b0; a_rsp_data = '0;
    b_rsp_valid = 1'b0; b_rsp_data = '0;
    if (rst_n && qa.size() != 0 && qa[0].due <= cyc) begin
      a_rsp_valid = 1'b1; a_rsp_data = qa[0].addr ^ KEY;
    end
    if (rst_n && qb.size() != 0 && qb[0].due <= cyc) begin
      b_rsp_valid = 1'b1; b_rsp_data = qb[0].addr ^ KEY;
    end
    #1;
    last_fire = a_req_valid & req_ready;
    if (!rst_n) begin
      qa.delete();
      qb.delete();
    end else begin
      assert (!(a_rsp_valid && dut.outstanding == '0)) else $error("protocol: response with nothing outstanding");
      assert (!(b_rsp_valid && dut_wrap.outstanding == '0)) else $error("protocol: response with nothing outstanding");
      if (a_rsp_valid) void'(qa.pop_front());
      if (b_rsp_valid) void'(qb.pop_front());
      if (a_req_valid && req_ready) qa.push_back('{addr: a_req_addr, due: 32'(cyc + lat)});
      if (b_req_valid && req_ready) qb.push_back('{addr: b_req_addr, due: 32'(cyc + lat)});
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_ready = 1'b1; id_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_ready = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0;
    tick(); tick();
    n_cmp++; if (a_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b expected 0", a_req_valid); end
    n_cmp++; if (a_instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_instr_valid: got %b expected 0", a_instr_valid); end
    n_cmp++; if (a_instr !== 32'h0000_0013) begin n_bad++; $display("FAIL reset_instr: got %h expected 00000013", a_instr); end
    n_cmp++; if (a_instr_pc !== 32'h0) begin n_bad++; $display("FAIL reset_instr_pc: got %h expected 00000000", a_instr_pc); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (a_req_valid !== 1'b1) begin n_bad++; $display("FAIL first_req_valid: got %b expected 1", a_req_valid); end
    n_cmp++; if (a_req_addr !== 32'h0) begin n_bad++; $display("FAIL first_req_addr: got %h expected 00000000", a_req_addr); end
    n_cmp++; if (b_req_addr !== 32'hFFFF_FFF8) begin n_bad++; $display("FAIL first_req_addr_wrap: got %h expected fffffff8", b_req_addr); end
  endtask

  // Free-run then a 10-cycle decode stall and release.
  task automatic test_free_run_and_stall();
    logic [31:0] exp_pc;
    lat = 1;
    do_reset();
    tick();
    n_cmp++; if (a_instr_valid !== 1'b0) begin n_bad++; $display("FAIL run_first_gap: got %b expected 0", a_instr_valid); end
    for (int unsigned i = 0; i < 8; i++) begin
      tick();
      exp_pc = 32'(4 * i);
      n_cmp++; if (a_instr_valid !== 1'b1) begin n_bad++; $display("FAIL run_valid[%0d]: got %b expected 1", i, a_instr_valid); end
      n_cmp++; if (a_instr_pc !== exp_pc) begin n_bad++; $display("FAIL run_pc[%0d]: got %h expected %h", i, a_instr_pc, exp_pc); end
      n_cmp++; if (a_instr !== (exp_pc ^ KEY)) begin n_bad++; $display("FAIL run_instr[%0d]: got %h expected %h", i, a_instr, exp_pc ^ KEY); end
    end
    id_ready = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (a_instr_pc !== 32'd28) begin n_bad++; $display("FAIL stall_pc[%0d]: got %h expected 0000001c", i, a_instr_pc); end
      n_cmp++; if (a_instr !== (32'd28 ^ KEY)) begin n_bad++; $display("FAIL stall_instr[%0d]: got %h expected %h", i, a_instr, 32'd28 ^ KEY); end
      n_cmp++; if (last_fire !== 1'b0) begin n_bad++; $display("FAIL stall_no_req[%0d]: got %b expected 0", i, last_fire); end
    end
    n_cmp++; if (a_req_valid !== 1'b0) begin n_bad++; $display("FAIL stall_req_valid: got %b expected 0", a_req_valid); end
    n_cmp++; if ((dut.count + dut.outstanding) != 2) begin n_bad++; $display("FAIL stall_credit: got %0d expected 2", dut.count + dut.outstanding); end
    id_ready = 1'b1;
    for (int unsigned i = 1; i <= 6; i++) begin
      tick();
      exp_pc = 32'(28 + 4 * i);
      n_cmp++; if (a_instr_valid !== 1'b1 || a_instr_pc !== exp_pc) begin n_bad++; $display("FAIL resume_pc[%0d]: got %b/%h expected 1/%h", i, a_instr_valid, a_instr_pc, exp_pc); end
    end
  endtask

  task automatic test_redirect_latency();
    int unsigned waited;
    lat = 3;
    do_reset();
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (a_req_addr !== 32'h100) begin n_bad++; $display("FAIL redir_addr: got %h expected 00000100", a_req_addr); end
    n_cmp++; if (a_instr_valid !== 1'b0) begin n_bad++; $display("FAIL redir_flush: got %b expected 0", a_instr_valid); end
    n_cmp++; if (dut.kill !== 2'd2) begin n_bad++; $display("FAIL redir_kill: got %0d expected 2", dut.kill); end
    waited = 0;
    for (int i = 0; i < 20 && a_instr_valid !== 1'b1; i++) begin
      tick();
      waited++;
    end
    n_cmp++; if (a_instr_valid !== 1'b1) begin n_bad++; $display("FAIL redir_timeout: got %b expected 1", a_instr_valid); end
    n_cmp++; if (waited != 5) begin n_bad++; $display("FAIL redir_latency: got %0d expected 5", waited); end
    n_cmp++; if (a_instr_pc !== 32'h100) begin n_bad++; $display("FAIL redir_first_pc: got %h expected 00000100", a_instr_pc); end
    n_cmp++; if (a_instr !== (32'h100 ^ KEY)) begin n_bad++; $display("FAIL redir_first_instr: got %h expected %h", a_instr, 32'h100 ^ KEY); end
  endtask

  // Redirect coinciding with a response and a decode pop.
  task automatic test_redirect_collision();
    lat = 1;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (a_instr_pc !== 32'd8) begin n_bad++; $display("FAIL coll_pre_pc: got %h expected 00000008", a_instr_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (a_instr_valid !== 1'b0) begin n_bad++; $display("FAIL coll_valid: got %b expected 0", a_instr_valid); end
    n_cmp++; if (dut.count !== 2'd0) begin n_bad++; $display("FAIL coll_count: got %0d expected 0", dut.count); end
    n_cmp++; if (dut.kill !== 2'd0) begin n_bad++; $display("FAIL coll_kill: got %0d expected 0", dut.kill); end
    n_cmp++; if (dut.outstanding !== 2'd0) begin n_bad++; $display("FAIL coll_outstanding: got %0d expected 0", dut.outstanding); end
    n_cmp++; if (a_req_addr !== 32'h200) begin n_bad++; $display("FAIL coll_addr: got %h expected 00000200", a_req_addr); end
    tick(); tick();
    n_cmp++; if (a_instr_valid !== 1'b1 || a_instr_pc !== 32'h200) begin n_bad++; $display("FAIL coll_first: got %b/%h expected 1/00000200", a_instr_valid, a_instr_pc); end
    n_cmp++; if (a_instr !== (32'h200 ^ KEY)) begin n_bad++; $display("FAIL coll_instr: got %h expected %h", a_instr, 32'h200 ^ KEY); end
  endtask

  task automatic test_ready_toggle();
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    lat = 1;
    do_reset();
    for (int unsigned k = 0; k < 8; k++) begin
      req_ready = (k % 2 == 0);
      tick();
      exp_addr = 32'(4 * (k / 2 + 1));
      exp_pc   = 32'(4 * (k / 2));
      n_cmp++; if (a_req_addr !== exp_addr) begin n_bad++; $display("FAIL toggle_addr[%0d]: got %h expected %h", k, a_req_addr, exp_addr); end
      if (k % 2 == 1) begin
        n_cmp++; if (a_instr_valid !== 1'b1 || a_instr_pc !== exp_pc) begin n_bad++; $display("FAIL toggle_pc[%0d]: got %b/%h expected 1/%h", k, a_instr_valid, a_instr_pc, exp_pc); end
      end else begin
        n_cmp++; if (a_instr_valid !== 1'b0) begin n_bad++; $display("FAIL toggle_gap[%0d]: got %b expected 0", k, a_instr_valid); end
      end
    end
    req_ready = 1'b1;
  endtask

  task automatic test_pc_wrap();
    logic [31:0] exp_pc;
    lat = 1;
    do_reset();
    tick();
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      exp_pc = 32'hFFFF_FFF8 + 32'(4 * i);
      n_cmp++; if (b_instr_valid !== 1'b1 || b_instr_pc !== exp_pc) begin n_bad++; $display("FAIL wrap_pc[%0d]: got %b/%h expected 1/%h", i, b_instr_valid, b_instr_pc, exp_pc); end
      n_cmp++; if (b_instr !== (exp_pc ^ KEY)) begin n_bad++; $display("FAIL wrap_instr[%0d]: got %h expected %h", i, b_instr, exp_pc ^ KEY); end
    end
  endtask

  initial begin
    a_rsp_valid = 1'b0; a_rsp_data = '0;
    b_rsp_valid = 1'b0; b_rsp_data = '0;
    test_reset();
    test_free_run_and_stall();
    test_redirect_latency();
    test_redirect_collision();
    test_ready_toggle();
    test_pc_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule
